csm_port_master: RTL and testbench

CSM_PORT_MASTER -- requirements
Module: csm_port_master

---
 rtl/csm_pkg.sv | 15 +
 rtl/csm_wait_timer.sv | 35 +++
 rtl/csm_port_master.sv | 164 ++++++++++++++++
 tb/tb_csm_port_master.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csm_pkg.sv
// Shared state encoding, status codes and bus width for the CSM port master.
package csm_pkg;
   localparam int         CSM_AD_W        = 8;
   localparam logic [1:0] CSM_ERR_OK      = 2'b00;
   localparam logic [1:0] CSM_ERR_TIMEOUT = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      HOLD,
      ADDR,
      DATA,
      REL,
      RESP
   } csm_mst_state_t;
endpackage

// File: rtl/csm_wait_timer.sv
// Saturating wait-cycle counter; expired is combinational in the TIMEOUT_CYC-th enabled cycle.
// Latency: 0 cycles from count to expired; no backpressure (free-running while enabled).
module csm_wait_timer #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC - 1);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q counts completed wait cycles, so the current cycle is number cnt_q+1.
   assign expired = enable && (cnt_q >= LIMIT);
endmodule

// File: rtl/csm_port_master.sv
// Single-request master for one CSM port: hold, address, data, release, respond; 5 cycles minimum
// request to rsp_valid, req_ready only in IDLE. Optional wait timeout under CSM_MASTER_TIMEOUT_EN.
module csm_port_master
   import csm_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_rw,
   input  logic [CSM_AD_W-1:0] req_addr,
   input  logic [CSM_AD_W-1:0] req_wdata,
   output logic                rsp_valid,
   output logic [CSM_AD_W-1:0] rsp_rdata,
   output logic [1:0]          rsp_err,
   output logic [CSM_AD_W-1:0] csm_in_AD,
   output logic                csm_rw,
   output logic                csm_enable,
   output logic                csm_hold,
   output logic                csm_release,
   input  logic                csm_ack,
   input  logic [1:0]          csm_err,
   input  logic [CSM_AD_W-1:0] csm_out_data
);
   if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 255)) begin : g_bad_cfg
      $error("csm_port_master: TIMEOUT_CYC must be within 2..255");
   end

   csm_mst_state_t      state_q, state_d;
   logic                rw_q, rw_d;
   logic [CSM_AD_W-1:0] addr_q, addr_d;
   logic [CSM_AD_W-1:0] wdata_q, wdata_d;
   logic [CSM_AD_W-1:0] cap_rdata_q, cap_rdata_d;
   logic [1:0]          cap_err_q, cap_err_d;
   logic [CSM_AD_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]          rsp_err_q, rsp_err_d;
   logic                idle_rdy;
   logic                tmo;

`ifdef CSM_MASTER_TIMEOUT_EN
   logic tmr_clear;
   logic tmr_enable;

   assign tmr_enable = (state_q == HOLD) || (state_q == DATA);
   assign tmr_clear  = (state_d != state_q) && ((state_d == HOLD) || (state_d == DATA));

   csm_wait_timer #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_wait_timer (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (tmr_clear),
      .enable (tmr_enable),
      .expired(tmo)
   );
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cap_rdata_d = cap_rdata_q;
      cap_err_d   = cap_err_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      idle_rdy    = 1'b0;
      rsp_valid   = 1'b0;
      csm_in_AD   = '0;
      csm_rw      = 1'b0;
      csm_enable  = 1'b0;
      csm_hold    = 1'b0;
      csm_release = 1'b0;
      case (state_q)
         IDLE: begin
            idle_rdy = 1'b1;
            if (req_valid) begin
               rw_d    = req_rw;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               state_d = HOLD;
            end
         end
         HOLD: begin
            csm_hold = 1'b1;
            // A grant arriving in the expiry cycle still wins over the timeout.
            if (csm_ack) begin
               state_d = ADDR;
            end else if (tmo) begin
               cap_rdata_d = '0;
               cap_err_d   = CSM_ERR_TIMEOUT;
               state_d     = REL;
            end
         end
         ADDR: begin
            csm_hold   = 1'b1;
            csm_enable = 1'b1;
            csm_rw     = rw_q;
            csm_in_AD  = addr_q;
            state_d    = DATA;
         end
         DATA: begin
            csm_hold   = 1'b1;
            csm_rw     = rw_q;
            csm_enable = !rw_q;
            csm_in_AD  = rw_q ? '0 : wdata_q;
            if (csm_ack) begin
               cap_rdata_d = rw_q ? csm_out_data : '0;
               cap_err_d   = csm_err;
               state_d     = REL;
            end else if (tmo) begin
               cap_rdata_d = '0;
               cap_err_d   = CSM_ERR_TIMEOUT;
               state_d     = REL;
            end
         end
         REL: begin
            csm_release = 1'b1;
            // Response registers only move here, so they stay stable from RESP to the next RESP.
            rsp_rdata_d = cap_rdata_q;
            rsp_err_d   = cap_err_q;
            state_d     = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cap_rdata_q <= '0;
         cap_err_q   <= CSM_ERR_OK;
         rsp_rdata_q <= '0;
         rsp_err_q   <= CSM_ERR_OK;
      end else begin
         state_q     <= state_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cap_rdata_q <= cap_rdata_d;
         cap_err_q   <= cap_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Gated by reset_n so the master never advertises ready while held in reset.
   assign req_ready = idle_rdy && reset_n;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_csm_port_master.sv
// Directed bench: a per-cycle expectation timeline is derived from each transaction's grant/data delays.
// Outputs are compared against that timeline on every falling edge, plus literal spot checks.
`timescale 1ns/1ps
module tb_csm_port_master;
   localparam int MAXC = 1024;
   localparam int TMO  = 4;
   localparam int HANG = 100;
`ifdef CSM_MASTER_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   typedef struct packed {
      logic       ready;
      logic       hold;
      logic       en;
      logic       rel;
      logic       rw;
      logic [7:0] ad;
      logic       rvld;
   } ctl_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_rw = 1'b0;
   logic [7:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic [1:0] rsp_err;
   logic [7:0] csm_in_AD;
   logic       csm_rw;
   logic       csm_enable;
   logic       csm_hold;
   logic       csm_release;
   logic       csm_ack = 1'b0;
   logic [1:0] csm_err = '0;
   logic [7:0] csm_out_data = '0;

   csm_port_master #(.TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .csm_in_AD(csm_in_AD), .csm_rw(csm_rw), .csm_enable(csm_enable),
      .csm_hold(csm_hold), .csm_release(csm_release),
      .csm_ack(csm_ack), .csm_err(csm_err), .csm_out_data(csm_out_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit         s_rstn [MAXC];
   bit         s_vld  [MAXC];
   bit         s_rw   [MAXC];
   logic [7:0] s_addr [MAXC];
   logic [7:0] s_wdata[MAXC];
   bit         s_ack  [MAXC];
   logic [1:0] s_err  [MAXC];
   logic [7:0] s_odata[MAXC];
   ctl_t       e_ctl  [MAXC];
   logic [7:0] e_rd   [MAXC];
   logic [1:0] e_er   [MAXC];

   int   checks = 0;
   int   errors = 0;
   bit   built = 1'b0;
   int   end_cyc = MAXC;
   int   t;
   int   r;
   ctl_t got;

   function automatic ctl_t mk(input bit rdy, input bit hd, input bit en, input bit rl,
                               input bit rw, input logic [7:0] ad, input bit rv);
      mk = '{ready: rdy, hold: hd, en: en, rel: rl, rw: rw, ad: ad, rvld: rv};
   endfunction

   task automatic fill(input int k, input int n, input ctl_t v);
      for (int j = k; j < k + n; j++) e_ctl[j] = v;
   endtask

   task automatic set_rsp_from(input int k, input logic [7:0] rd, input logic [1:0] er);
      for (int j = k; j < MAXC; j++) begin
         e_rd[j] = rd;
         e_er[j] = er;
      end
   endtask

   // Reset from cycle k0 for n cycles; everything after k0 restarts from an idle master.
   task automatic do_reset(input int k0, input int n);
      for (int j = k0; j < MAXC; j++) begin
         s_rstn[j] = (j >= k0 + n);
         s_vld[j] = 1'b0; s_ack[j] = 1'b0; s_err[j] = '0; s_odata[j] = '0;
         e_ctl[j] = (j < k0 + n) ? mk(0, 0, 0, 0, 0, 8'h00, 0) : mk(1, 0, 0, 0, 0, 8'h00, 0);
      end
      set_rsp_from(k0, 8'h00, 2'b00);
   endtask

   task automatic hold_req(input int from, input int to, input bit rw,
                           input logic [7:0] addr, input logic [7:0] wd);
      for (int j = from; j <= to; j++) begin
         s_vld[j] = 1'b1; s_rw[j] = rw; s_addr[j] = addr; s_wdata[j] = wd;
      end
   endtask

   // g/d: wait cycles before grant/data ack (negative = never). noise pulses ack in ADDR/REL/RESP.
   task automatic txn(input int a, input bit rw, input logic [7:0] addr, input logic [7:0] wd,
                      input int g, input int d, input logic [1:0] cerr, input logic [7:0] od,
                      input bit noise, output int nxt);
      int         k;
      logic [7:0] rd;
      logic [1:0] er;
      ctl_t       dv;
      s_vld[a] = 1'b1; s_rw[a] = rw; s_addr[a] = addr; s_wdata[a] = wd;
      dv = mk(0, 1, !rw, 0, rw, rw ? 8'h00 : wd, 0);
      k = a + 1;
      rd = 8'h00;
      er = 2'b11;
      if (g >= 0 && (!TMO_EN || g < TMO)) begin
         fill(k, g + 1, mk(0, 1, 0, 0, 0, 8'h00, 0));
         s_ack[k + g] = 1'b1;
         k = k + g + 1;
         e_ctl[k] = mk(0, 1, 1, 0, rw, addr, 0);
         if (noise) s_ack[k] = 1'b1;
         k = k + 1;
         if (d >= 0 && (!TMO_EN || d < TMO)) begin
            fill(k, d + 1, dv);
            s_ack[k + d] = 1'b1; s_err[k + d] = cerr; s_odata[k + d] = od;
            k = k + d + 1;
            rd = rw ? od : 8'h00;
            er = cerr;
         end else if (TMO_EN) begin
            fill(k, TMO, dv);
            k = k + TMO;
         end else begin
            fill(k, HANG, dv);
            nxt = k + HANG;
            return;
         end
      end else if (TMO_EN) begin
         fill(k, TMO, mk(0, 1, 0, 0, 0, 8'h00, 0));
         k = k + TMO;
      end else begin
         fill(k, HANG, mk(0, 1, 0, 0, 0, 8'h00, 0));
         nxt = k + HANG;
         return;
      end
      e_ctl[k] = mk(0, 0, 0, 1, 0, 8'h00, 0);
      if (noise) s_ack[k] = 1'b1;
      k = k + 1;
      e_ctl[k] = mk(0, 0, 0, 0, 0, 8'h00, 1);
      set_rsp_from(k, rd, er);
      if (noise) s_ack[k] = 1'b1;
      nxt = k + 1;
   endtask

   task automatic drive(input int k);
      reset_n = s_rstn[k]; req_valid = s_vld[k]; req_rw = s_rw[k];
      req_addr = s_addr[k]; req_wdata = s_wdata[k];
      csm_ack = s_ack[k]; csm_err = s_err[k]; csm_out_data = s_odata[k];
   endtask

   task automatic at_cyc(input int k);
      while (cyc < k) @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, req);
      end
   endtask

   initial begin
      wait (built);
      drive(0);
      forever begin
         @(posedge clk);
         #1;
         if (cyc < MAXC) drive(cyc);
      end
   end

   always @(negedge clk) begin
      if (built && cyc >= 1 && cyc < end_cyc) begin
         got = '{ready: req_ready, hold: csm_hold, en: csm_enable, rel: csm_release,
                 rw: csm_rw, ad: csm_in_AD, rvld: rsp_valid};
         checks++;
         if (got !== e_ctl[cyc] || rsp_rdata !== e_rd[cyc] || rsp_err !== e_er[cyc]) begin
            errors++;
            $display("FAIL timeline cycle %0d: ctl got %b want %b, rdata got %h want %h, err got %b want %b",
                     cyc, got, e_ctl[cyc], rsp_rdata, e_rd[cyc], rsp_err, e_er[cyc]);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int j = 0; j < MAXC; j++) begin
         s_rstn[j] = 1'b1; s_vld[j] = 1'b0; s_rw[j] = 1'b0; s_addr[j] = '0; s_wdata[j] = '0;
         s_ack[j] = 1'b0; s_err[j] = '0; s_odata[j] = '0;
         e_ctl[j] = mk(1, 0, 0, 0, 0, 8'h00, 0);
         e_rd[j] = '0; e_er[j] = '0;
      end
      do_reset(0, 3);
      txn(4, 1'b0, 8'h3C, 8'hA5, 0, 0, 2'b00, 8'h00, 1'b0, t);   // ends at 10
      txn(11, 1'b1, 8'h10, 8'h00, 2, 1, 2'b00, 8'h5A, 1'b1, t);  // ends at 20
      txn(t, 1'b0, 8'h77, 8'h12, 1, 2, 2'b01, 8'hEE, 1'b1, t);   // ends at 29
      txn(t, 1'b1, 8'h81, 8'h00, 0, 0, 2'b10, 8'hC3, 1'b1, t);   // ends at 35
      hold_req(30, 34, 1'b0, 8'h42, 8'h99);
      txn(t, 1'b0, 8'h42, 8'h99, 0, 0, 2'b00, 8'h00, 1'b0, t);   // ends at 41
      txn(42, 1'b1, 8'h55, 8'h00, -1, 0, 2'b00, 8'h00, 1'b0, t);
      if (TMO_EN) begin
         txn(50, 1'b1, 8'h56, 8'h00, 0, -1, 2'b00, 8'hBB, 1'b0, t);
      end else begin
         do_reset(t, 2);
         t = t + 2;
      end
      r = t;
      txn(r, 1'b0, 8'h5E, 8'hE7, 0, 3, 2'b00, 8'h00, 1'b0, t);
      do_reset(r + 4, 2);
      txn(r + 7, 1'b1, 8'h20, 8'h00, 0, 0, 2'b00, 8'h66, 1'b0, t);
      end_cyc = r + 15;
      built = 1'b1;

      at_cyc(1);  chk("reset_ready", {7'd0, req_ready}, 8'h00);
                  chk("reset_outs", {5'd0, csm_hold, csm_enable, rsp_valid}, 8'h00);
      at_cyc(3);  chk("ready_after_release", {7'd0, req_ready}, 8'h01);
      at_cyc(6);  chk("wr_addr_phase", csm_in_AD, 8'h3C);
      at_cyc(7);  chk("wr_data_phase", csm_in_AD, 8'hA5);
      at_cyc(8);  chk("wr_release", {7'd0, csm_release}, 8'h01);
      at_cyc(9);  chk("wr_rsp_lat5", {5'd0, rsp_valid, rsp_err}, 8'h04);
      at_cyc(16); chk("rd_data_enable_low", {7'd0, csm_enable}, 8'h00);
      at_cyc(19); chk("rd_rdata", rsp_rdata, 8'h5A);
      at_cyc(28); chk("wr_err01", {6'd0, rsp_err}, 8'h01);
      at_cyc(30); chk("b2b_busy_ready", {7'd0, req_ready}, 8'h00);
      if (TMO_EN) begin
         at_cyc(47); chk("hold_tmo_release", {6'd0, csm_hold, csm_release}, 8'h01);
         at_cyc(48); chk("hold_tmo_err", {6'd0, rsp_err}, 8'h03);
      end else begin
         at_cyc(142); chk("hold_no_tmo", {7'd0, csm_hold}, 8'h01);
      end
      at_cyc(r + 4);  chk("reset_in_data", {6'd0, csm_hold, csm_enable}, 8'h00);
      at_cyc(r + 12); chk("post_reset_rdata", rsp_rdata, 8'h66);
      at_cyc(end_cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
